// File: rtl/vga_pkg.sv
// Shared display types and character codes for the menu/overlay logic.
package vga_pkg;
  typedef enum logic [2:0] {
    MODE_MENU     = 3'd0,
    MODE_PLAY     = 3'd1,
    MODE_STORY    = 3'd2,
    MODE_ABOUT    = 3'd3,
    MODE_CONTROLS = 3'd4
  } mode_t;

  typedef enum logic {ST_MENU, ST_ITEM} menu_st_t;

  localparam int         N_MENU_ITEMS = 4;
  localparam logic [6:0] SPACE        = 7'h20;
  localparam logic [6:0] MARKER       = 7'h41;
endpackage

// File: rtl/menu_ctl_if.sv
// Button inputs, text-grid overlay path and menu status outputs.
interface menu_ctl_if;
  import vga_pkg::*;
  logic       btn_up, btn_down, btn_enter, btn_back;
  logic [7:0] char_xy;
  logic [6:0] char_code_in;
  logic [6:0] char_code_out;
  logic [1:0] cursor;
  mode_t      mode;
  logic       mode_change;

  modport master (output btn_up, btn_down, btn_enter, btn_back, char_xy, char_code_in,
                  input  char_code_out, cursor, mode, mode_change);
  modport slave  (input  btn_up, btn_down, btn_enter, btn_back, char_xy, char_code_in,
                  output char_code_out, cursor, mode, mode_change);
endinterface

// File: rtl/menu_ctl_btn_repeat.sv
// Rising-edge detect plus hold/auto-repeat timer; step_o pulses once per move.
module menu_btn_repeat #(
  parameter int HOLD_CYCLES   = 32_500_000,
  parameter int REPEAT_CYCLES = 9_750_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic clr_i,
  output logic step_o
);
  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

  logic          prev_q, run_q, rep_q;
  logic          run_d, rep_d, rpt, edge_det;
  logic [CW-1:0] cnt_q, cnt_d;

  assign edge_det = btn_i & ~prev_q;

  // The counter only runs after a genuine edge, so a level held through
  // reset or through an ITEM screen never starts repeating on its own.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    rep_d = rep_q;
    rpt   = 1'b0;
    if (!btn_i || clr_i) begin
      cnt_d = '0; run_d = 1'b0; rep_d = 1'b0;
    end else if (edge_det) begin
      cnt_d = '0; run_d = 1'b1; rep_d = 1'b0;
    end else if (run_q) begin
      if (!rep_q && cnt_q == CW'(HOLD_CYCLES - 1)) begin
        rpt = 1'b1; cnt_d = '0; rep_d = 1'b1;
      end else if (rep_q && cnt_q == CW'(REPEAT_CYCLES - 1)) begin
        rpt = 1'b1; cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign step_o = (edge_det | rpt) & ~clr_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b1;
      run_q  <= 1'b0;
      rep_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= btn_i;
      run_q  <= run_d;
      rep_q  <= rep_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/menu_ctl.sv
// Menu cursor/mode FSM with the selection-marker overlay on the text stream.
module menu_ctl
  import vga_pkg::*;
#(
  parameter int N_ITEMS       = N_MENU_ITEMS,
  parameter int HOLD_CYCLES   = 32_500_000,
  parameter int REPEAT_CYCLES = 9_750_000
) (
  input  logic      clk,
  input  logic      rst,
  menu_ctl_if.slave mbus
);
  menu_st_t   state_q, state_d;
  logic [1:0] cursor_q, cursor_d;
  mode_t      mode_q, mode_d;
  logic       mc_q, mc_d;
  logic       prev_ent_q, prev_back_q, ent_edge, back_edge;
  logic       up_step, dn_step, in_item;
  logic [7:0] xy_q;
  logic [6:0] code_q, code_d;

  assign in_item   = (state_q != ST_MENU);
  assign ent_edge  = mbus.btn_enter & ~prev_ent_q;
  assign back_edge = mbus.btn_back & ~prev_back_q;

  // Each direction is cleared by the other being held, which also cancels
  // simultaneous up+down edges.
  menu_btn_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_up (
    .clk(clk), .rst(rst), .btn_i(mbus.btn_up),
    .clr_i(mbus.btn_down | in_item), .step_o(up_step));
  menu_btn_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dn (
    .clk(clk), .rst(rst), .btn_i(mbus.btn_down),
    .clr_i(mbus.btn_up | in_item), .step_o(dn_step));

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    mode_d   = mode_q;
    mc_d     = 1'b0;
    case (state_q)
      ST_MENU: begin
        if (ent_edge) begin
          state_d = ST_ITEM;
          mode_d  = mode_t'(MODE_PLAY + {1'b0, cursor_q});
          mc_d    = 1'b1;
        end else if (up_step) begin
          cursor_d = (cursor_q == 2'd0) ? 2'(N_ITEMS - 1) : cursor_q - 2'd1;
        end else if (dn_step) begin
          cursor_d = (cursor_q == 2'(N_ITEMS - 1)) ? 2'd0 : cursor_q + 2'd1;
        end
      end
      default: begin
        if (back_edge) begin
          state_d = ST_MENU;
          mode_d  = MODE_MENU;
          mc_d    = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    code_d = mbus.char_code_in;
    if (xy_q[3:0] == 4'd1 && 32'(xy_q[7:4]) < N_ITEMS)
      code_d = (xy_q[7:4] == {2'b00, cursor_q} && state_q == ST_MENU) ? MARKER : SPACE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_MENU;
      cursor_q    <= 2'd0;
      mode_q      <= MODE_MENU;
      mc_q        <= 1'b0;
      prev_ent_q  <= 1'b1;
      prev_back_q <= 1'b1;
      xy_q        <= 8'd0;
      code_q      <= SPACE;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      mode_q      <= mode_d;
      mc_q        <= mc_d;
      prev_ent_q  <= mbus.btn_enter;
      prev_back_q <= mbus.btn_back;
      xy_q        <= mbus.char_xy;
      code_q      <= code_d;
    end
  end

  assign mbus.cursor        = cursor_q;
  assign mbus.mode          = mode_q;
  assign mbus.mode_change   = mc_q;
  assign mbus.char_code_out = code_q;
endmodule
